// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO reader: controller states and default widths.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order output buffer between the FIFO read port and the stream.
// Entry 0 is always the head; a clear discards everything in one cycle.
module fifo_rd_skid #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    input  logic                  i_clear,
    output logic [1:0]            o_occ,
    output logic [DATA_WIDTH-1:0] o_head
);

    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_mem0;
    logic [DATA_WIDTH-1:0] r_mem1;
    logic                  w_pop;

    // A pop of an empty buffer is meaningless, so it is ignored here.
    always_comb begin
        w_pop = i_pop && (r_occ != 2'd0);
    end

    // Occupancy and entry update; a push together with a pop keeps occupancy
    // and moves the new word in behind whatever remains.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_occ  <= 2'd0;
            r_mem0 <= '0;
            r_mem1 <= '0;
        end else if (w_pop && i_push) begin
            if (r_occ == 2'd1) begin
                r_mem0 <= i_push_data;
            end else begin
                r_mem0 <= r_mem1;
                r_mem1 <= i_push_data;
            end
        end else if (w_pop) begin
            r_mem0 <= r_mem1;
            r_occ  <= r_occ - 2'd1;
        end else if (i_push && (r_occ != 2'd2)) begin
            if (r_occ == 2'd0) begin
                r_mem0 <= i_push_data;
            end else begin
                r_mem1 <= i_push_data;
            end
            r_occ <= r_occ + 2'd1;
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem0;

endmodule

// File: rtl/fifo_reader.sv
// FIFO reader: pulls words from a one-cycle-latency FIFO into a two-entry
// buffer and presents them as a valid/ready stream, with a flush mode that
// discards buffered data and drains the attached FIFO.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  flush_done,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_inflight;
    logic                  r_flush_done;
    logic [CNT_WIDTH-1:0]  r_beat_cnt;

    logic [1:0]            w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_valid;
    logic                  w_beat;
    logic                  w_push;
    logic                  w_clear;
    logic                  w_flush_exit;
    logic                  w_rd_en;
    logic [2:0]            w_projected;

    // Stream handshake and buffer control; captured words are dropped in FLUSH,
    // and an accepted flush empties the buffer at the same edge.
    always_comb begin
        w_valid      = (w_occ != 2'd0) && (r_state != FLUSH);
        w_beat       = w_valid && m_ready;
        w_projected  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_beat};
        w_flush_exit = (r_state == FLUSH) && fifo_empty && !r_inflight;
        w_clear      = flush && (r_state != FLUSH);
        w_push       = r_inflight && (r_state != FLUSH);
    end

    // Next-state and read-issue decisions; a read is only issued in STREAM
    // when the word is guaranteed a free buffer slot on arrival.
    always_comb begin
        w_next_state = r_state;
        w_rd_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_next_state = FLUSH;
                end else if (en) begin
                    w_next_state = STREAM;
                end
            end
            STREAM: begin
                w_rd_en = !fifo_empty && (w_projected < 3'd2);
                if (flush) begin
                    w_next_state = FLUSH;
                end else if (!en) begin
                    w_next_state = IDLE;
                end
            end
            FLUSH: begin
                w_rd_en = !fifo_empty;
                if (w_flush_exit) begin
                    w_next_state = en ? STREAM : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register, in-flight read tracking, beat counter and flush-done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_inflight   <= 1'b0;
            r_beat_cnt   <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_inflight   <= w_rd_en && !fifo_empty;
            r_flush_done <= w_flush_exit;
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (fifo_dout),
        .i_pop       (w_beat),
        .i_clear     (w_clear),
        .o_occ       (w_occ),
        .o_head      (w_head)
    );

    // Outputs are forced to their idle values whenever reset is asserted.
    assign fifo_rd_en = rst_n && w_rd_en;
    assign m_valid    = rst_n && w_valid;
    assign m_data     = rst_n ? w_head : '0;
    assign busy       = rst_n && (r_state == FLUSH);
    assign flush_done = rst_n && r_flush_done;
    assign beat_cnt   = rst_n ? r_beat_cnt : '0;

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: an attached-FIFO model plus a
// queue-based reference model of the reader, with directed and random phases.
module tb_fifo_reader;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          flush;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          m_ready;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          busy;
    logic          flush_done;
    logic [CW-1:0] beat_cnt;

    logic          wRdEn;
    logic [DW-1:0] wData;
    logic          wValid;
    logic          wBusy;
    logic          wDone;
    logic [3:0]    wBeatCnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] envFifo[$];
    logic [DW-1:0] envDout = '0;

    int            mState = 0;
    logic [DW-1:0] mBuf[$];
    bit            mInflight = 1'b0;
    int unsigned   mCnt = 0;
    bit            mDone = 1'b0;

    always #5 clk = ~clk;

    fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .flush_done (flush_done),
        .beat_cnt   (beat_cnt)
    );

    fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dutW4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (wRdEn),
        .m_data     (wData),
        .m_valid    (wValid),
        .m_ready    (m_ready),
        .busy       (wBusy),
        .flush_done (wDone),
        .beat_cnt   (wBeatCnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic loadFifo(input int first, input int count);
        for (int k = 0; k < count; k++) begin
            envFifo.push_back(DW'(first + k));
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance
    // the attached FIFO and the model by the rules of one rising edge.
    task automatic applyStimulus(input bit iEn, input bit iFlush, input bit iReady, input bit iRstn);
        bit wasEmpty;
        bit pValid;
        bit pBeat;
        bit pRd;
        bit dutRd;
        int nState;
        rst_n      = iRstn;
        en         = iEn;
        flush      = iFlush;
        m_ready    = iReady;
        wasEmpty   = (envFifo.size() == 0);
        fifo_empty = wasEmpty;
        fifo_dout  = envDout;
        #1;
        pValid = iRstn && (mState != 2) && (mBuf.size() > 0);
        pBeat  = pValid && iReady;
        pRd    = 1'b0;
        if (iRstn && mState == 1) begin
            pRd = !wasEmpty && ((int'(mBuf.size()) + int'(mInflight) - int'(pBeat)) < 2);
        end else if (iRstn && mState == 2) begin
            pRd = !wasEmpty;
        end
        checkOutput("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, pRd});
        checkOutput("m_valid", {31'd0, m_valid}, {31'd0, pValid});
        if (pValid) begin
            checkOutput("m_data", {24'd0, m_data}, {24'd0, mBuf[0]});
        end
        if (!iRstn) begin
            checkOutput("m_data_rst", {24'd0, m_data}, 32'd0);
        end
        checkOutput("busy", {31'd0, busy}, {31'd0, iRstn && (mState == 2)});
        checkOutput("flush_done", {31'd0, flush_done}, {31'd0, iRstn && mDone});
        checkOutput("beat_cnt", {16'd0, beat_cnt}, iRstn ? (mCnt & 32'hFFFF) : 32'd0);
        checkOutput("beat_cnt_w4", {28'd0, wBeatCnt}, iRstn ? (mCnt & 32'hF) : 32'd0);
        dutRd = fifo_rd_en;
        @(posedge clk);
        @(negedge clk);
        if (!iRstn) begin
            mState    = 0;
            mBuf.delete();
            mInflight = 1'b0;
            mCnt      = 0;
            mDone     = 1'b0;
        end else begin
            nState = mState;
            if (pBeat) begin
                void'(mBuf.pop_front());
                mCnt++;
            end
            mDone = (mState == 2) && wasEmpty && !mInflight;
            if (mState != 2 && iFlush) begin
                mBuf.delete();
                nState = 2;
            end else begin
                if (mState != 2 && mInflight) begin
                    mBuf.push_back(envDout);
                end
                if (mState == 0 && iEn) nState = 1;
                else if (mState == 1 && !iEn) nState = 0;
                else if (mState == 2 && mDone) nState = iEn ? 1 : 0;
            end
            mInflight = pRd;
            mState    = nState;
        end
        if (dutRd && envFifo.size() > 0) begin
            envDout = envFifo.pop_front();
        end
    endtask

    // Hard stop in case anything ever stalls the stimulus sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized phase and the summary.
    initial begin
        int pulses;
        int savedCnt;
        bit rEn;
        bit rFlush;
        bit rReady;
        bit rRst;
        rst_n      = 1'b0;
        en         = 1'b0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        @(negedge clk);

        repeat (3) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("reset_cnt", {16'd0, beat_cnt}, 32'd0);

        // Sixteen words straight through with the consumer always ready.
        loadFifo(1, 16);
        repeat (24) applyStimulus(1, 0, 1, 1);
        checkOutput("stream16_cnt", {16'd0, beat_cnt}, 32'd16);
        checkOutput("stream16_wrap_w4", {28'd0, wBeatCnt}, 32'd0);
        checkOutput("stream16_drained", envFifo.size(), 32'd0);

        // Consumer stalls for five cycles right after the first beat.
        loadFifo(1, 16);
        for (int k = 0; k < 10 && mCnt < 17; k++) applyStimulus(1, 0, 1, 1);
        checkOutput("first_beat_seen", mCnt, 32'd17);
        repeat (5) applyStimulus(1, 0, 0, 1);
        checkOutput("stall_data", {24'd0, m_data}, 32'h02);
        checkOutput("stall_valid", {31'd0, m_valid}, 32'd1);
        checkOutput("stall_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        repeat (30) applyStimulus(1, 0, 1, 1);
        checkOutput("stall_total", {16'd0, beat_cnt}, 32'd32);

        // Flush with a full buffer and ten words in the FIFO.
        loadFifo(8'h40, 10);
        repeat (6) applyStimulus(1, 0, 0, 1);
        savedCnt = 32;
        applyStimulus(1, 1, 0, 1);
        checkOutput("flush_mvalid", {31'd0, m_valid}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 0, 0, 1);
            if (flush_done) pulses++;
        end
        checkOutput("flush_pulses", pulses, 32'd1);
        checkOutput("flush_drained", envFifo.size(), 32'd0);
        checkOutput("flush_cnt_held", {16'd0, beat_cnt}, savedCnt);

        // Drop enable while a read is in flight.
        loadFifo(8'h80, 4);
        applyStimulus(1, 0, 1, 1);
        repeat (10) applyStimulus(0, 0, 1, 1);
        checkOutput("en_drop_left", envFifo.size(), 32'd2);
        checkOutput("en_drop_cnt", {16'd0, beat_cnt}, 32'd34);
        repeat (10) applyStimulus(1, 0, 1, 1);
        checkOutput("en_resume_cnt", {16'd0, beat_cnt}, 32'd36);

        // Reset in the middle of streaming, then resume.
        loadFifo(8'hA0, 8);
        repeat (4) applyStimulus(1, 0, 1, 1);
        repeat (2) applyStimulus(1, 0, 1, 0);
        repeat (20) applyStimulus(1, 0, 1, 1);

        // Reset in the middle of a flush, then resume.
        loadFifo(8'hC0, 10);
        repeat (6) applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 1, 0, 1);
        repeat (2) applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        repeat (20) applyStimulus(1, 0, 1, 1);

        // Randomized traffic, flushes, enable changes and occasional resets.
        rEn = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0 && envFifo.size() < 24) begin
                for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                    envFifo.push_back(DW'($urandom));
                end
            end
            if ($urandom_range(0, 19) == 0) rEn = ~rEn;
            rFlush = ($urandom_range(0, 39) == 0);
            rReady = ($urandom_range(0, 9) < 7);
            rRst   = ($urandom_range(0, 299) != 0);
            applyStimulus(rEn, rFlush, rReady, rRst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
